// File: rtl/mp64_extmem_arbiter.sv
// ---------------------------------------------------------------------------
// mp64_extmem_arbiter
//
// Shares the single external-memory PHY port between NUM_REQ on-chip
// requesters (cluster L2 refill, DMA, NIC buffers). It grants requesters in
// round-robin order, one burst at a time. It also drives the PHY
// command/write-beat handshake and counts read beats back to the granted
// requester.
//
// Optional feature macro: MP64_EXTMEM_ARB_TIMEOUT_EN
//   When defined, a read burst that sees no beat for TIMEOUT_CYCLES cycles
//   is aborted with an rsp_err pulse. When undefined, rsp_err_o is tied to 0
//   and a read burst waits for its beats indefinitely.
//
// Parameters:
//   NUM_REQ         number of requesters (2..8)
//   TIMEOUT_CYCLES  read-beat watchdog limit (only with the macro)
//
// Ports:
//   clk_i, rst_i       clock, synchronous active-high reset
//   req_valid_i        per-requester command request, held until rsp_done
//   req_addr_i         burst start address, slice i = [64*i +: 64]
//   req_wen_i          1 = write burst, 0 = read burst
//   req_len_i          beats minus one, slice i = [8*i +: 8]
//   req_wdata_i        current write beat, slice i = [64*i +: 64]
//   req_gnt_o          one-hot grant, held for the whole burst
//   req_wready_o       write beat accepted by the PHY this cycle
//   rsp_rdata_o        shared read data, valid with rsp_rvalid_o
//   rsp_rvalid_o       read beat for requester i this cycle
//   rsp_done_o         one-cycle pulse on the final beat of a burst
//   rsp_err_o          one-cycle pulse when a burst is aborted by timeout
//   phy_req_o          command / write-beat valid towards the PHY
//   phy_addr_o         burst address
//   phy_wen_o          write flag
//   phy_wdata_o        write beat
//   phy_burst_len_o    beats minus one
//   phy_rdata_i        read beat from the PHY
//   phy_rvalid_i       read beat valid
//   phy_ready_i        PHY accepts the current phy_req_o cycle
// ---------------------------------------------------------------------------
module mp64_extmem_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic [NUM_REQ-1:0]     req_valid_i,
   input  logic [NUM_REQ*64-1:0]  req_addr_i,
   input  logic [NUM_REQ-1:0]     req_wen_i,
   input  logic [NUM_REQ*8-1:0]   req_len_i,
   input  logic [NUM_REQ*64-1:0]  req_wdata_i,
   output logic [NUM_REQ-1:0]     req_gnt_o,
   output logic [NUM_REQ-1:0]     req_wready_o,
   output logic [63:0]            rsp_rdata_o,
   output logic [NUM_REQ-1:0]     rsp_rvalid_o,
   output logic [NUM_REQ-1:0]     rsp_done_o,
   output logic [NUM_REQ-1:0]     rsp_err_o,
   output logic                   phy_req_o,
   output logic [63:0]            phy_addr_o,
   output logic                   phy_wen_o,
   output logic [63:0]            phy_wdata_o,
   output logic [7:0]             phy_burst_len_o,
   input  logic [63:0]            phy_rdata_i,
   input  logic                   phy_rvalid_i,
   input  logic                   phy_ready_i
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   // Reject configurations outside the supported requester range at elaboration.
   if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
      $error("mp64_extmem_arbiter: unsupported NUM_REQ or TIMEOUT_CYCLES");
   end

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CMD   = 2'd1,
      WDATA = 2'd2,
      RDATA = 2'd3
   } state_e;

   state_e             state_q, state_d;
   logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0]   gnt_idx_q, gnt_idx_d;
   logic [NUM_REQ-1:0] gnt_q, gnt_d;
   logic [7:0]         cnt_q, cnt_d;

   logic [63:0]        sel_addr;
   logic [63:0]        sel_wdata;
   logic               sel_wen;
   logic [7:0]         sel_len;

   logic               pick_found;
   logic [IDX_W-1:0]   pick_idx;
   int                 cand;
   logic [IDX_W-1:0]   cand_idx;
   logic [IDX_W-1:0]   next_ptr;

   logic               done_ev;
   logic               wready_ev;
   logic               rvalid_ev;

`ifdef MP64_EXTMEM_ARB_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TMO_W-1:0]   tmo_q, tmo_d;
   logic               err_ev;
`endif

   // Pick out the command fields of the currently granted requester.
   always_comb begin
      sel_addr  = '0;
      sel_wdata = '0;
      sel_wen   = 1'b0;
      sel_len   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt_idx_q == IDX_W'(i)) begin
            sel_addr  = req_addr_i[64*i +: 64];
            sel_wdata = req_wdata_i[64*i +: 64];
            sel_wen   = req_wen_i[i];
            sel_len   = req_len_i[8*i +: 8];
         end
      end
   end

   // Round-robin search: first requesting index at or after the pointer,
   // wrapping modulo NUM_REQ.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      cand       = 0;
      cand_idx   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = int'(rr_ptr_q) + k;
         if (cand >= NUM_REQ) begin
            cand = cand - NUM_REQ;
         end
         cand_idx = IDX_W'(cand);
         if (!pick_found && req_valid_i[cand_idx]) begin
            pick_found = 1'b1;
            pick_idx   = cand_idx;
         end
      end
   end

   // The requester after the one that just finished gets first priority next.
   assign next_ptr = (gnt_idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx_q + 1'b1;

   // Next-state and output logic. A burst that finishes (done or timeout)
   // clears the grant and goes back to IDLE. This guarantees one idle cycle
   // between bursts, because arbitration only happens in IDLE.
   always_comb begin
      state_d         = state_q;
      rr_ptr_d        = rr_ptr_q;
      gnt_idx_d       = gnt_idx_q;
      gnt_d           = gnt_q;
      cnt_d           = cnt_q;
      phy_req_o       = 1'b0;
      phy_addr_o      = '0;
      phy_wen_o       = 1'b0;
      phy_wdata_o     = '0;
      phy_burst_len_o = '0;
      rsp_rdata_o     = '0;
      done_ev         = 1'b0;
      wready_ev       = 1'b0;
      rvalid_ev       = 1'b0;
`ifdef MP64_EXTMEM_ARB_TIMEOUT_EN
      tmo_d           = tmo_q;
      err_ev          = 1'b0;
`endif

      unique case (state_q)
         IDLE: begin
            if (pick_found) begin
               gnt_idx_d       = pick_idx;
               gnt_d           = '0;
               gnt_d[pick_idx] = 1'b1;
               state_d         = CMD;
            end
         end

         CMD: begin
            phy_req_o       = 1'b1;
            phy_addr_o      = sel_addr;
            phy_wen_o       = sel_wen;
            phy_wdata_o     = sel_wdata;
            phy_burst_len_o = sel_len;
            if (phy_ready_i) begin
               cnt_d = sel_len;
               if (sel_wen) begin
                  // The first write beat travels with the command.
                  wready_ev = 1'b1;
                  if (sel_len == 8'd0) begin
                     done_ev  = 1'b1;
                     gnt_d    = '0;
                     rr_ptr_d = next_ptr;
                     state_d  = IDLE;
                  end else begin
                     state_d = WDATA;
                  end
               end else begin
                  state_d = RDATA;
`ifdef MP64_EXTMEM_ARB_TIMEOUT_EN
                  tmo_d   = '0;
`endif
               end
            end
         end

         WDATA: begin
            phy_req_o       = 1'b1;
            phy_addr_o      = sel_addr;
            phy_wen_o       = sel_wen;
            phy_wdata_o     = sel_wdata;
            phy_burst_len_o = sel_len;
            if (phy_ready_i) begin
               wready_ev = 1'b1;
               if (cnt_q == 8'd1) begin
                  done_ev  = 1'b1;
                  gnt_d    = '0;
                  rr_ptr_d = next_ptr;
                  state_d  = IDLE;
               end else begin
                  cnt_d = cnt_q - 8'd1;
               end
            end
         end

         RDATA: begin
            rsp_rdata_o = phy_rdata_i;
            if (phy_rvalid_i) begin
               rvalid_ev = 1'b1;
`ifdef MP64_EXTMEM_ARB_TIMEOUT_EN
               tmo_d     = '0;
`endif
               if (cnt_q == 8'd0) begin
                  done_ev  = 1'b1;
                  gnt_d    = '0;
                  rr_ptr_d = next_ptr;
                  state_d  = IDLE;
               end else begin
                  cnt_d = cnt_q - 8'd1;
               end
            end
`ifdef MP64_EXTMEM_ARB_TIMEOUT_EN
            else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
               err_ev   = 1'b1;
               gnt_d    = '0;
               rr_ptr_d = next_ptr;
               state_d  = IDLE;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
`endif
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      // A reset mid-burst aborts silently, so no event may leak out while
      // reset is held.
      if (rst_i) begin
         done_ev   = 1'b0;
         wready_ev = 1'b0;
         rvalid_ev = 1'b0;
`ifdef MP64_EXTMEM_ARB_TIMEOUT_EN
         err_ev    = 1'b0;
`endif
      end
   end

   // Per-requester pulses are the granted one-hot vector masked by the event.
   assign req_gnt_o    = gnt_q;
   assign req_wready_o = gnt_q & {NUM_REQ{wready_ev}};
   assign rsp_rvalid_o = gnt_q & {NUM_REQ{rvalid_ev}};
   assign rsp_done_o   = gnt_q & {NUM_REQ{done_ev}};
`ifdef MP64_EXTMEM_ARB_TIMEOUT_EN
   assign rsp_err_o    = gnt_q & {NUM_REQ{err_ev}};
`else
   assign rsp_err_o    = '0;
`endif

   // State registers with synchronous reset back to IDLE and pointer zero.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         rr_ptr_q  <= '0;
         gnt_idx_q <= '0;
         gnt_q     <= '0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         rr_ptr_q  <= rr_ptr_d;
         gnt_idx_q <= gnt_idx_d;
         gnt_q     <= gnt_d;
         cnt_q     <= cnt_d;
      end
   end

`ifdef MP64_EXTMEM_ARB_TIMEOUT_EN
   // Cycles since the read command was accepted or since the last read beat.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         tmo_q <= '0;
      end else begin
         tmo_q <= tmo_d;
      end
   end
`endif

endmodule

// File: tb/tb_mp64_extmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mp64_extmem_arbiter
//
// Directed bench for the external-memory arbiter with NUM_REQ=4 and
// TIMEOUT_CYCLES=16. Inputs change and outputs are sampled around the falling
// clock edge; the DUT registers on the rising edge.
// ---------------------------------------------------------------------------
module tb_mp64_extmem_arbiter;

   localparam int N = 4;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [N-1:0]   req_valid = '0;
   logic [N*64-1:0] req_addr = '0;
   logic [N-1:0]   req_wen = '0;
   logic [N*8-1:0] req_len = '0;
   logic [N*64-1:0] req_wdata = '0;
   logic [N-1:0]   req_gnt;
   logic [N-1:0]   req_wready;
   logic [63:0]    rsp_rdata;
   logic [N-1:0]   rsp_rvalid;
   logic [N-1:0]   rsp_done;
   logic [N-1:0]   rsp_err;
   logic           phy_req;
   logic [63:0]    phy_addr;
   logic           phy_wen;
   logic [63:0]    phy_wdata;
   logic [7:0]     phy_burst_len;
   logic [63:0]    phy_rdata = '0;
   logic           phy_rvalid = 1'b0;
   logic           phy_ready = 1'b0;

   int totalChecks = 0;
   int badChecks   = 0;

   bit readyPat [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

   mp64_extmem_arbiter #(
      .NUM_REQ        (N),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk_i           (clk),
      .rst_i           (rst),
      .req_valid_i     (req_valid),
      .req_addr_i      (req_addr),
      .req_wen_i       (req_wen),
      .req_len_i       (req_len),
      .req_wdata_i     (req_wdata),
      .req_gnt_o       (req_gnt),
      .req_wready_o    (req_wready),
      .rsp_rdata_o     (rsp_rdata),
      .rsp_rvalid_o    (rsp_rvalid),
      .rsp_done_o      (rsp_done),
      .rsp_err_o       (rsp_err),
      .phy_req_o       (phy_req),
      .phy_addr_o      (phy_addr),
      .phy_wen_o       (phy_wen),
      .phy_wdata_o     (phy_wdata),
      .phy_burst_len_o (phy_burst_len),
      .phy_rdata_i     (phy_rdata),
      .phy_rvalid_i    (phy_rvalid),
      .phy_ready_i     (phy_ready)
   );

   // Free-running 10 ns clock.
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [63:0] actual,
                              input logic [63:0] expected);
      totalChecks++;
      if (actual !== expected) begin
         badChecks++;
         $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, actual, expected);
      end
   endtask

   // Load one requester's command fields.
   task automatic applyStimulus(input int r, input logic valid, input logic wen,
                                input logic [7:0] len, input logic [63:0] addr);
      req_valid[r]         = valid;
      req_wen[r]           = wen;
      req_len[r*8 +: 8]    = len;
      req_addr[r*64 +: 64] = addr;
   endtask

   // Hold reset for two cycles and check that every output is quiet.
   task automatic doReset();
      rst        = 1'b1;
      req_valid  = '0;
      phy_ready  = 1'b0;
      phy_rvalid = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      checkOutput("rst_gnt",     64'(req_gnt),    64'h0);
      checkOutput("rst_phy_req", 64'(phy_req),    64'h0);
      checkOutput("rst_done",    64'(rsp_done),   64'h0);
      checkOutput("rst_addr",    phy_addr,        64'h0);
      rst = 1'b0;
   endtask

   // Run one read burst. The caller has already set the request inputs; the
   // burst is accepted on its first CMD cycle and the beats arrive back to
   // back. On return the DUT is in its idle cycle and the requester's valid
   // has been dropped.
   task automatic readBurst(input int idx, input int beats,
                            input logic [63:0] expAddr, input logic [63:0] dataBase);
      logic [N-1:0] oh;
      oh = N'(1) << idx;
      @(negedge clk);
      phy_ready = 1'b1;
      #1;
      checkOutput($sformatf("rd%0d_gnt", idx),     64'(req_gnt),       64'(oh));
      checkOutput($sformatf("rd%0d_phy_req", idx), 64'(phy_req),       64'h1);
      checkOutput($sformatf("rd%0d_addr", idx),    phy_addr,           expAddr);
      checkOutput($sformatf("rd%0d_wen", idx),     64'(phy_wen),       64'h0);
      checkOutput($sformatf("rd%0d_len", idx),     64'(phy_burst_len), 64'(beats - 1));
      @(negedge clk);
      phy_ready = 1'b0;
      for (int b = 0; b < beats; b++) begin
         phy_rvalid = 1'b1;
         phy_rdata  = dataBase + 64'(b);
         #1;
         checkOutput($sformatf("rd%0d_rvalid%0d", idx, b), 64'(rsp_rvalid), 64'(oh));
         checkOutput($sformatf("rd%0d_rdata%0d", idx, b),  rsp_rdata,       dataBase + 64'(b));
         checkOutput($sformatf("rd%0d_done%0d", idx, b),   64'(rsp_done),
                     (b == beats - 1) ? 64'(oh) : 64'h0);
         @(negedge clk);
      end
      phy_rvalid     = 1'b0;
      req_valid[idx] = 1'b0;
      #1;
      checkOutput($sformatf("rd%0d_idle_gnt", idx), 64'(req_gnt), 64'h0);
      checkOutput($sformatf("rd%0d_idle_req", idx), 64'(phy_req), 64'h0);
   endtask

   initial begin
      int wrCount;
      int beat;

      $display("[TB] start");
      doReset();

      // Single 4-beat read from requester 1; phy_req must stay low in the
      // cycle the request first appears.
      applyStimulus(1, 1'b1, 1'b0, 8'd3, 64'h1000);
      #1;
      checkOutput("t1_req_same_cycle", 64'(phy_req), 64'h0);
      readBurst(1, 4, 64'h1000, 64'hA0);

      // Round-robin ordering from a fresh pointer of zero.
      doReset();
      applyStimulus(0, 1'b1, 1'b0, 8'd0, 64'h2000);
      applyStimulus(2, 1'b1, 1'b0, 8'd0, 64'h2200);
      readBurst(0, 1, 64'h2000, 64'hC0);
      readBurst(2, 1, 64'h2200, 64'hC1);
      applyStimulus(0, 1'b1, 1'b0, 8'd0, 64'h2000);
      applyStimulus(2, 1'b1, 1'b0, 8'd0, 64'h2200);
      readBurst(0, 1, 64'h2000, 64'hC2);
      for (int i = 0; i < N; i++) begin
         applyStimulus(i, 1'b1, 1'b0, 8'd0, 64'h2000 + 64'(i) * 64'h100);
      end
      readBurst(1, 1, 64'h2100, 64'hC3);
      readBurst(2, 1, 64'h2200, 64'hC4);
      readBurst(3, 1, 64'h2300, 64'hC5);
      readBurst(0, 1, 64'h2000, 64'hC6);

      // 3-beat write from requester 3 with a stalling PHY.
      applyStimulus(3, 1'b1, 1'b1, 8'd2, 64'h4000);
      beat    = 0;
      wrCount = 0;
      @(negedge clk);
      for (int c = 0; c < 6; c++) begin
         phy_ready           = readyPat[c];
         req_wdata[3*64 +: 64] = 64'hB0 + 64'(beat);
         #1;
         checkOutput($sformatf("wr_phy_req%0d", c), 64'(phy_req),    64'h1);
         checkOutput($sformatf("wr_wen%0d", c),     64'(phy_wen),    64'h1);
         checkOutput($sformatf("wr_addr%0d", c),    phy_addr,        64'h4000);
         checkOutput($sformatf("wr_wdata%0d", c),   phy_wdata,       64'hB0 + 64'(beat));
         checkOutput($sformatf("wr_wready%0d", c),  64'(req_wready), readyPat[c] ? 64'h8 : 64'h0);
         checkOutput($sformatf("wr_done%0d", c),    64'(rsp_done),   (c == 5) ? 64'h8 : 64'h0);
         if (req_wready[3]) wrCount++;
         if (readyPat[c]) beat++;
         @(negedge clk);
      end
      phy_ready    = 1'b0;
      req_valid[3] = 1'b0;
      #1;
      checkOutput("wr_pulse_count", 64'(wrCount), 64'd3);
      checkOutput("wr_idle_gnt",    64'(req_gnt), 64'h0);

      // Advance the pointer to 2, start an 8-beat read from requester 2 and
      // reset it after two beats.
      applyStimulus(1, 1'b1, 1'b0, 8'd0, 64'h5000);
      readBurst(1, 1, 64'h5000, 64'hD0);
      applyStimulus(2, 1'b1, 1'b0, 8'd7, 64'h6000);
      @(negedge clk);
      phy_ready = 1'b1;
      @(negedge clk);
      phy_ready = 1'b0;
      for (int b = 0; b < 2; b++) begin
         phy_rvalid = 1'b1;
         phy_rdata  = 64'hE0 + 64'(b);
         @(negedge clk);
      end
      rst = 1'b1;
      @(negedge clk);
      rst        = 1'b0;
      phy_rvalid = 1'b0;
      req_valid  = '0;
      #1;
      checkOutput("mid_rst_gnt",    64'(req_gnt),    64'h0);
      checkOutput("mid_rst_req",    64'(phy_req),    64'h0);
      checkOutput("mid_rst_rvalid", 64'(rsp_rvalid), 64'h0);
      checkOutput("mid_rst_done",   64'(rsp_done),   64'h0);
      checkOutput("mid_rst_rdata",  rsp_rdata,       64'h0);
      // Pointer back at zero: requester 1 wins over requester 2.
      applyStimulus(1, 1'b1, 1'b0, 8'd0, 64'h5000);
      applyStimulus(2, 1'b1, 1'b0, 8'd0, 64'h6000);
      readBurst(1, 1, 64'h5000, 64'hD1);
      readBurst(2, 1, 64'h6000, 64'hD2);

      // Read of two beats from requester 0 where only the first beat arrives.
      applyStimulus(0, 1'b1, 1'b0, 8'd1, 64'h7000);
      @(negedge clk);
      phy_ready = 1'b1;
      #1;
      checkOutput("to_gnt", 64'(req_gnt), 64'h1);
      @(negedge clk);
      phy_ready  = 1'b0;
      phy_rvalid = 1'b1;
      phy_rdata  = 64'hF0;
      #1;
      checkOutput("to_rvalid", 64'(rsp_rvalid), 64'h1);
      checkOutput("to_done0",  64'(rsp_done),   64'h0);
      @(negedge clk);
      phy_rvalid = 1'b0;
      applyStimulus(1, 1'b1, 1'b0, 8'd0, 64'h7100);
`ifdef MP64_EXTMEM_ARB_TIMEOUT_EN
      for (int k = 1; k <= 16; k++) begin
         #1;
         checkOutput($sformatf("to_err%0d", k),  64'(rsp_err),  (k == 16) ? 64'h1 : 64'h0);
         checkOutput($sformatf("to_done%0d", k), 64'(rsp_done), 64'h0);
         @(negedge clk);
      end
      req_valid[0] = 1'b0;
      #1;
      checkOutput("to_idle_gnt", 64'(req_gnt), 64'h0);
      readBurst(1, 1, 64'h7100, 64'hF1);
`else
      repeat (40) @(negedge clk);
      #1;
      checkOutput("no_to_err",  64'(rsp_err),  64'h0);
      checkOutput("no_to_gnt",  64'(req_gnt),  64'h1);
      checkOutput("no_to_done", 64'(rsp_done), 64'h0);
      doReset();
      applyStimulus(1, 1'b1, 1'b0, 8'd0, 64'h7100);
      readBurst(1, 1, 64'h7100, 64'hF1);
`endif

      $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
      $finish;
   end

endmodule

// File: doc/mp64_extmem_arbiter.md
Name: mp64_extmem_arbiter

Overview:
Round-robin arbiter and burst sequencer sharing the single external-memory PHY port (phy_*) between NUM_REQ on-chip requesters (cluster L2 refill, DMA, NIC buffers). Each requester supplies one burst command. The block grants one requester at a time and drives the PHY command/write-beat handshake. It counts read beats back to the granted requester and signals burst completion.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
TIMEOUT_CYCLES, 1024, read-beat watchdog limit (used only with MP64_EXTMEM_ARB_TIMEOUT_EN)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active high
req_valid  in  NUM_REQ  per-requester command request; held until matching rsp_done
req_addr  in  NUM_REQ*64  burst start address, slice i = [64*i+:64]
req_wen  in  NUM_REQ  1=write burst, 0=read burst
req_len  in  NUM_REQ*8  beats minus one (0..255 -> 1..256 beats)
req_wdata  in  NUM_REQ*64  current write beat; advance on req_wready
req_gnt  out  NUM_REQ  one-hot grant, held for the whole burst
req_wready  out  NUM_REQ  write beat accepted by PHY this cycle
rsp_rdata  out  64  read data, shared, valid with rsp_rvalid
rsp_rvalid  out  NUM_REQ  read beat for requester i this cycle
rsp_done  out  NUM_REQ  one-cycle pulse: final beat of burst transferred
rsp_err  out  NUM_REQ  one-cycle pulse: burst aborted by timeout (0 without macro)
phy_req  out  1  command/write-beat valid
phy_addr  out  64  burst address
phy_wen  out  1  write flag
phy_wdata  out  64  write beat
phy_burst_len  out  8  beats minus one
phy_rdata  in  64  read beat
phy_rvalid  in  1  read beat valid
phy_ready  in  1  PHY accepts the current phy_req cycle

Behaviour:
- Reset: all outputs 0, state IDLE, RR pointer=0, beat counter=0. Reset mid-burst aborts silently (no done/err). The PHY is reset together.
- States: IDLE, CMD, WDATA, RDATA.
- IDLE: if any req_valid, pick the first set bit at or after the RR pointer, wrapping modulo NUM_REQ. Register the grant (req_gnt) and go to CMD. Latency: req_valid in cycle T -> phy_req=1 in T+1.
- CMD: phy_req=1; phy_addr/phy_wen/phy_burst_len = granted slice, stable until phy_ready. phy_wdata = granted req_wdata.
- Accept rule: a transfer happens when phy_req && phy_ready. The first write beat travels with the command.
- CMD accept, write: pulse req_wready[g]; load counter=req_len. If len==0, pulse rsp_done[g] and go IDLE; else go WDATA.
- WDATA: phy_req=1 with the same addr/wen/len. Each accept pulses req_wready[g] and decrements the counter. At the accept with counter==1, pulse rsp_done[g] and go IDLE.
- CMD accept, read: load counter=req_len, go RDATA; phy_req=0.
- RDATA: rsp_rdata=phy_rdata combinationally; rsp_rvalid[g]=phy_rvalid. On the beat with counter==0, pulse rsp_done[g] with that beat and go IDLE; otherwise decrement on each beat.
- phy_rvalid outside RDATA is ignored.
- On done or err: RR pointer = g+1 mod NUM_REQ; req_gnt clears the next cycle. There is always one IDLE cycle between bursts.
- A requester deasserting req_valid while granted is a protocol violation. The arbiter still completes the burst.
- No preemption; a burst runs to completion.
- rsp_rvalid, req_wready, rsp_done and rsp_err are nonzero only at bit g.

Optional Feature:
MP64_EXTMEM_ARB_TIMEOUT_EN
- Defined: in RDATA, a counter of cycles since the last beat (or since command accept) is kept. At TIMEOUT_CYCLES with no phy_rvalid, pulse rsp_err[g] (no rsp_done), advance the RR pointer and go IDLE. Any late beats are ignored.
- Undefined: no counter, rsp_err tied 0, RDATA waits indefinitely.

Test Plan:
- Read, req 1: addr=0x1000, len=3; phy_ready=1 first CMD cycle; 4 rvalid beats 0xA0..0xA3 -> phy_req rises T+1, rsp_rvalid[1] x4 with matching data, rsp_done[1] on 4th beat, req_gnt clears next cycle.
- Req 0 and req 2 assert together, pointer=0, each read len=0 -> req 0 served first, then req 2. Next simultaneous 0/2 request -> req 0 again (pointer=3 wraps to 0); all 4 asserted from pointer 1 -> order 1,2,3,0.
- Write, req 3: len=2, phy_ready pattern 0,1,0,0,1,1 -> 3 req_wready[3] pulses aligned with ready highs, phy_wdata follows req_wdata each beat, rsp_done[3] with 3rd accept.
- Reset asserted mid-RDATA after 2 of 8 beats -> next cycle all outputs 0, state IDLE, pointer 0. A new request afterwards completes normally.
- With MP64_EXTMEM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16: read len=1, one beat then silence -> rsp_err pulses at cycle 16 after that beat, no rsp_done, next requester granted. Without the macro -> stays in RDATA, rsp_err stays 0.
